// File: rtl/tick_countdown_pkg.sv
// Shared types for the tick-driven countdown: FSM state encoding and default width.
package tick_countdown_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } tc_state_t;

   localparam int TC_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/tick_countdown_if.sv
// Control/status bundle between the control logic (master) and tick_countdown (slave).
interface tick_countdown_if
   import tick_countdown_pkg::*;
#(
   parameter int WIDTH = TC_WIDTH_DEFAULT
);

   logic             tick;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic             pause;
   logic [WIDTH-1:0] count;
   logic             running;
   logic             done;

   modport master (
      output tick, load, load_value, start, pause,
      input  count, running, done
   );

   modport slave (
      input  tick, load, load_value, start, pause,
      output count, running, done
   );

endinterface

// File: rtl/tick_countdown.sv
// Programmable down-counter advanced by the tick timer strobe, with one-cycle done pulse.
// Build option: TICK_COUNTDOWN_AUTO_RELOAD_EN makes the final tick reload and keep running.
module tick_countdown
   import tick_countdown_pkg::*;
#(
   parameter int WIDTH = TC_WIDTH_DEFAULT
) (
   input  logic            clk,
   input  logic            reset_n,
   tick_countdown_if.slave bus
);

   tc_state_t        state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   // Priority load > pause > start > tick; pause masks start even where it is a no-op.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (bus.load) begin
         count_d  = bus.load_value;
         reload_d = bus.load_value;
         state_d  = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!bus.pause && bus.start && count_q != '0)
                  state_d = RUN;
            end
            RUN: begin
               if (bus.pause) begin
                  state_d = PAUSED;
               end else if (bus.tick) begin
                  if (count_q > WIDTH'(1)) begin
                     count_d = count_q - WIDTH'(1);
                  end else begin
                     done_d = 1'b1;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
                     count_d = reload_q;
`else
                     count_d = '0;
                     state_d = DONE;
`endif
                  end
               end
            end
            PAUSED: begin
               if (!bus.pause && bus.start)
                  state_d = RUN;
            end
            DONE: begin
               if (!bus.pause && bus.start && reload_q != '0) begin
                  count_d = reload_q;
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.count   = count_q;
   assign bus.running = (state_q == RUN);
   assign bus.done    = done_q;

endmodule

// File: doc/tick_countdown.md
# tick_countdown

Programmable down-counter consuming the single-cycle `tick` strobe of the upstream tick timer. It loads a count, decrements once per accepted tick while running, and flags completion with a one-cycle `done` pulse. It turns the periodic timer output into timeouts, delays and alarms for the control logic above it.

## Interface
Parameters:
- `WIDTH`, 16: width of the count and load value; range 2..32.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle strobe from the tick timer; only sampled in RUN.
- `load`  in  1  loads `load_value` into count and reload register.
- `load_value`  in  WIDTH  value captured on `load`.
- `start`  in  1  starts from IDLE/DONE, resumes from PAUSED.
- `pause`  in  1  freezes the countdown while in RUN.
- `count`  out  WIDTH  current remaining ticks, registered.
- `running`  out  1  high while state is RUN (decoded from state register).
- `done`  out  1  registered one-cycle completion pulse.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Reset (asserted asynchronously): state IDLE, `count` 0, reload register 0, `done` 0, `running` 0.
- Priority per cycle: `load` > `pause` > `start` > `tick`.
- `load` in any state: `count` and reload register <= `load_value`, state <= IDLE, `done` 0; `start`/`pause`/`tick` that cycle ignored.
- IDLE + `start`: if `count` != 0, go RUN; if `count` == 0, ignored (stay IDLE, no `done`).
- RUN + `pause`: go PAUSED; a coincident `tick` is dropped.
- RUN + `tick`, `count` > 1: `count` <= `count` - 1.
- RUN + `tick`, `count` == 1: `count` <= 0, `done` <= 1 for one cycle, state per Configuration.
- PAUSED: ticks ignored, `count` held; `start` returns to RUN.
- DONE: `count` stays 0; `start` reloads `count` from reload register and goes RUN (ignored if reload register is 0).
- `pause` outside RUN and `start` in RUN are no-ops.
- `count` never wraps: RUN with `count` 0 is unreachable.

## Timing
- `load` in cycle N -> `count` valid in cycle N+1.
- `start` in cycle N -> `running` high in N+1; first accepted tick can come in N+1.
- Final tick in cycle N -> `count` 0 and `done` high in N+1, `done` low in N+2.
- Load value L with one tick every P cycles: `done` rises L ticks after start, i.e. (L-1)*P+1 cycles after the first accepted tick.
- `reset_n` deasserted mid-countdown: all state lost, returns to reset values immediately (asynchronous); no `done` emitted.

## Configuration
- `TICK_COUNTDOWN_AUTO_RELOAD_EN` defined: on final tick, `count` <= reload register, state stays RUN, `done` still pulses; runs periodically until `pause` or `load`.
- Undefined: on final tick, state <= DONE; a new `start` is required.

## Structure
- Package `tick_countdown_pkg`: state enum `tc_state_t` (IDLE, RUN, PAUSED, DONE) and constant `TC_WIDTH_DEFAULT` = 16.
- No sub-module; the parent instantiates the tick timer and connects its `tick` to this block.

## Test plan
- Reset, `load` 5, `start`, `tick` every 4 cycles -> `count` 5,4,3,2,1,0; `done` high one cycle after 5th tick; state DONE.
- `load` 3, `start`, `pause` coincident with 2nd tick -> `count` stays 2, no decrement; ticks during PAUSED ignored; `start` resumes, `done` after 2 more ticks.
- `start` with `count` 0 after reset -> stays IDLE, `running` 0, no `done`.
- `load` 10 while RUN at `count` 4 with coincident `tick` -> `count` 10, IDLE, `running` 0.
- DONE after `load` 2, `start` -> `count` 2, RUN; with `TICK_COUNTDOWN_AUTO_RELOAD_EN` defined instead: `done` every 2 ticks, `count` 2,1,2,1..., never DONE.
- `reset_n` low mid-RUN at `count` 7 -> `count` 0, `running` 0, `done` 0 immediately, no pulse after release.
